// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide scheduler: op encodings,
// default latencies and FSM state type.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_arith.sv
// Combinational 32x32 multiply/divide datapath producing {hi,lo}.
// Signed division runs on magnitudes so 0x80000000 / -1 wraps cleanly.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_div_by_zero
);

    logic [63:0] w_smul;
    logic [63:0] w_umul;
    logic        w_b_zero;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_mag_q;
    logic [31:0] w_mag_r;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [31:0] w_uq;
    logic [31:0] w_ur;

    assign w_smul   = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_umul   = {32'd0, i_a} * {32'd0, i_b};
    assign w_b_zero = (i_b == 32'd0);

    assign w_mag_a = i_a[31] ? (32'd0 - i_a) : i_a;
    assign w_mag_b = i_b[31] ? (32'd0 - i_b) : i_b;
    assign w_mag_q = w_b_zero ? 32'd0 : (w_mag_a / w_mag_b);
    assign w_mag_r = w_b_zero ? 32'd0 : (w_mag_a % w_mag_b);

    // quotient truncates toward zero, remainder follows the dividend sign
    assign w_sq = (i_a[31] ^ i_b[31]) ? (32'd0 - w_mag_q) : w_mag_q;
    assign w_sr = i_a[31] ? (32'd0 - w_mag_r) : w_mag_r;

    assign w_uq = w_b_zero ? 32'd0 : (i_a / i_b);
    assign w_ur = w_b_zero ? 32'd0 : (i_a % i_b);

    always_comb begin
        o_hi          = 32'd0;
        o_lo          = 32'd0;
        o_div_by_zero = 1'b0;
        case (i_op)
            MD_MULT: begin
                o_hi = w_smul[63:32];
                o_lo = w_smul[31:0];
            end
            MD_MULTU: begin
                o_hi = w_umul[63:32];
                o_lo = w_umul[31:0];
            end
            MD_DIV: begin
                o_hi          = w_sr;
                o_lo          = w_sq;
                o_div_by_zero = w_b_zero;
            end
            MD_DIVU: begin
                o_hi          = w_ur;
                o_lo          = w_uq;
                o_div_by_zero = w_b_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_scheduler.sv
// Multiply/divide sequencing controller: owns HI/LO, models MD latency
// with a down-counter and requests ID-stage stalls while an op is pending.
//
//  state | meaning
//  IDLE  | no op in flight; accepts mult/div/mthi/mtlo
//  BUSY  | mult/div in flight; counter runs down, commit at count 1
module md_scheduler
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cancel,
    input  logic        md_use_id,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    md_state_e   r_state;
    md_state_e   w_state_nxt;
    logic [CW-1:0] r_count;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_dz;

    logic        w_valid_op;
    logic        w_is_arith;
    logic        w_is_div;
    logic        w_accept;
    logic        w_last;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_div_by_zero;

    md_arith u_arith (
        .i_op          (op),
        .i_a           (A),
        .i_b           (B),
        .o_hi          (w_res_hi),
        .o_lo          (w_res_lo),
        .o_div_by_zero (w_div_by_zero)
    );

    assign w_valid_op = (op <= MD_MTLO);
    assign w_is_arith = (op <= MD_DIVU);
    assign w_is_div   = (op == MD_DIV) || (op == MD_DIVU);
    assign w_accept   = start & ~cancel & ~busy & w_valid_op;
    assign w_last     = (r_count == CW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_is_arith) w_state_nxt = BUSY;
            BUSY:    if (w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_dz <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_accept) begin
                if (w_is_arith) begin
                    r_count   <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    r_pend_hi <= w_res_hi;
                    r_pend_lo <= w_res_lo;
                    r_pend_dz <= w_div_by_zero;
                end else if (op == MD_MTHI) begin
                    r_hi <= A;
                end else begin
                    r_lo <= A;
                end
            end
        end else if (w_last) begin
            r_count <= '0;
            // divide by zero keeps the architectural HI/LO untouched
            if (!r_pend_dz) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
        end else begin
            r_count <= r_count - CW'(1);
        end
    end

    assign busy  = (r_state == BUSY);
    assign stall = md_use_id & (busy | (start & ~cancel & w_valid_op));
    assign HI    = r_hi;
    assign LO    = r_lo;

endmodule

// File: tb/tb_md_scheduler.sv
// Directed self-checking bench for md_scheduler with default latencies.
module tb_md_scheduler;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        cancel;
    logic        md_use_id;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad   = 0;

    md_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .A         (A),
        .B         (B),
        .cancel    (cancel),
        .md_use_id (md_use_id),
        .busy      (busy),
        .stall     (stall),
        .HI        (HI),
        .LO        (LO)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one op in the current cycle, then counts busy cycles (bounded).
    // Returns in the cycle where busy has dropped again.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int n);
        start = 1'b1; op = o; A = a; B = b;
        step();
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
        cancel = 1'b0; md_use_id = 1'b0;
        step(); step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
        total++; if (HI !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want 0", HI); end
        total++; if (LO !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want 0", LO); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_mult();
        int n;
        do_op(MD_MULT, 32'hFFFF_FFFF, 32'd2, n);
        total++; if (n != 5) begin bad++; $display("FAIL mult_cycles: got %0d want 5", n); end
        total++; if (HI !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi: got %h want ffffffff", HI); end
        total++; if (LO !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mult_lo: got %h want fffffffe", LO); end
    endtask

    task automatic test_multu();
        int n;
        do_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, n);
        total++; if (n != 5) begin bad++; $display("FAIL multu_cycles: got %0d want 5", n); end
        total++; if (HI !== 32'h0000_0001) begin bad++; $display("FAIL multu_hi: got %h want 00000001", HI); end
        total++; if (LO !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_lo: got %h want fffffffe", LO); end
    endtask

    task automatic test_div();
        int n;
        do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, n);
        total++; if (n != 10) begin bad++; $display("FAIL div_cycles: got %0d want 10", n); end
        total++; if (LO !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo: got %h want fffffffd", LO); end
        total++; if (HI !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi: got %h want ffffffff", HI); end
        do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
        total++; if (LO !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_lo: got %h want 80000000", LO); end
        total++; if (HI !== 32'd0) begin bad++; $display("FAIL div_ovf_hi: got %h want 0", HI); end
        do_op(MD_DIVU, 32'd100, 32'd7, n);
        total++; if (LO !== 32'd14 || HI !== 32'd2) begin
            bad++; $display("FAIL divu: got hi=%h lo=%h want hi=2 lo=e", HI, LO);
        end
    endtask

    task automatic test_divu_zero();
        int n;
        start = 1'b1; op = MD_MTHI; A = 32'h1234;
        step();
        op = MD_MTLO;
        step();
        start = 1'b0;
        do_op(MD_DIVU, 32'd7, 32'd0, n);
        total++; if (n != 10) begin bad++; $display("FAIL divz_cycles: got %0d want 10", n); end
        total++; if (HI !== 32'h1234 || LO !== 32'h1234) begin
            bad++; $display("FAIL divz_hold: got hi=%h lo=%h want 1234/1234", HI, LO);
        end
    endtask

    task automatic test_mthi();
        start = 1'b1; op = MD_MTHI; A = 32'hDEAD_BEEF;
        step();
        start = 1'b0;
        total++; if (HI !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mthi_hi: got %h want deadbeef", HI); end
        total++; if (LO !== 32'h1234) begin bad++; $display("FAIL mthi_lo: got %h want 1234", LO); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mthi_busy: got %b want 0", busy); end
        start = 1'b1; op = MD_MTLO; A = 32'h0BAD_F00D;
        step();
        start = 1'b0;
        total++; if (LO !== 32'h0BAD_F00D || HI !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL mtlo: got hi=%h lo=%h want deadbeef/0badf00d", HI, LO);
        end
    endtask

    task automatic test_cancel();
        start = 1'b1; op = MD_MULT; A = 32'd5; B = 32'd6; cancel = 1'b1; md_use_id = 1'b1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL cancel_stall: got %b want 0", stall); end
        step();
        start = 1'b0; cancel = 1'b0; md_use_id = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_busy: got %b want 0", busy); end
        repeat (6) step();
        total++; if (HI !== 32'hDEAD_BEEF || LO !== 32'h0BAD_F00D) begin
            bad++; $display("FAIL cancel_hilo: got hi=%h lo=%h want deadbeef/0badf00d", HI, LO);
        end
    endtask

    task automatic test_stall();
        start = 1'b1; op = MD_MULT; A = 32'd3; B = 32'd4; md_use_id = 1'b1;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL stall_start: got %b want 1", stall); end
        step();
        start = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (busy !== 1'b1 || stall !== 1'b1) begin
                bad++; $display("FAIL stall_busy%0d: got busy=%b stall=%b want 1/1", i, busy, stall);
            end
            step();
        end
        total++; if (busy !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL stall_release: got busy=%b stall=%b want 0/0", busy, stall);
        end
        total++; if (HI !== 32'd0 || LO !== 32'd12) begin
            bad++; $display("FAIL stall_result: got hi=%h lo=%h want 0/c", HI, LO);
        end
        md_use_id = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        do_op(MD_MULTU, 32'h0001_0000, 32'h0001_0000, n);
        do_op(MD_MULT, 32'd7, 32'hFFFF_FFFD, n);
        total++; if (n != 5) begin bad++; $display("FAIL b2b_cycles: got %0d want 5", n); end
        total++; if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFEB) begin
            bad++; $display("FAIL b2b_result: got hi=%h lo=%h want ffffffff/ffffffeb", HI, LO);
        end
        // a start while busy must be ignored
        start = 1'b1; op = MD_MULTU; A = 32'd9; B = 32'd9;
        step();
        op = MD_MTHI; A = 32'hFFFF_0000;
        step();
        start = 1'b0;
        repeat (6) step();
        total++; if (HI !== 32'd0 || LO !== 32'd81) begin
            bad++; $display("FAIL busy_ignore: got hi=%h lo=%h want 0/51", HI, LO);
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; op = MD_MTLO; A = 32'h77;
        step();
        op = MD_DIV; A = 32'd100; B = 32'd7;
        step();
        start = 1'b0;
        repeat (3) step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_pre: got busy=%b want 1", busy); end
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            bad++; $display("FAIL rstmid_now: got busy=%b hi=%h lo=%h want 0/0/0", busy, HI, LO);
        end
        step();
        reset = 1'b0;
        repeat (12) step();
        total++; if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            bad++; $display("FAIL rstmid_late: got busy=%b hi=%h lo=%h want 0/0/0", busy, HI, LO);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_divu_zero();
        test_mthi();
        test_cancel();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
